// File: rtl/dot_layer_merger.sv
// dot_layer_merger
//   Consumer end of the dot-generator FIFO interface. Pops all layer FIFOs
//   together, composites one pixel per read by fixed priority (layer 0 is
//   frontmost) with a transparent colour key, and streams the merged pixel
//   with its screen coordinates over a valid/ready handshake.
//
// Ports
//   iClk, iRst   clock, synchronous active-high reset
//   iHdisplay    active pixels per line (static during a frame)
//   iVdisplay    active lines per frame (static during a frame)
//   iBgColor     colour emitted when every layer is transparent
//   iLayerEmp    per-layer FIFO empty flags
//   oLayerEdd    read enable broadcast to every layer FIFO
//   iLayerVdd    per-layer read-data valid, one clock after oLayerEdd
//   iLayerDd     per-layer read data, layer k at [k*pColorDepth +: pColorDepth]
//   oPixel       merged pixel (head of the output buffer)
//   oHpos/oVpos  screen coordinates of oPixel
//   oVd          oPixel/oHpos/oVpos valid
//   iRdy         downstream ready; transfer on oVd & iRdy
//   oFe          pulses with the accept of the last pixel of a frame
//   oSkewErr     sticky: a read returned without every layer valid
module dot_layer_merger #(
    parameter int                     pLayerNum      = 4,
    parameter int                     pColorDepth    = 16,
    parameter int                     pHdisplayWidth = 11,
    parameter int                     pVdisplayWidth = 11,
    parameter logic [pColorDepth-1:0] pTransColor    = 16'h0000
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic [pHdisplayWidth-1:0]       iHdisplay,
    input  logic [pVdisplayWidth-1:0]       iVdisplay,
    input  logic [pColorDepth-1:0]          iBgColor,
    input  logic [pLayerNum-1:0]            iLayerEmp,
    output logic                            oLayerEdd,
    input  logic [pLayerNum-1:0]            iLayerVdd,
    input  logic [pLayerNum*pColorDepth-1:0] iLayerDd,
    output logic [pColorDepth-1:0]          oPixel,
    output logic [pHdisplayWidth-1:0]       oHpos,
    output logic [pVdisplayWidth-1:0]       oVpos,
    output logic                            oVd,
    input  logic                            iRdy,
    output logic                            oFe,
    output logic                            oSkewErr
);

    localparam logic [pHdisplayWidth-1:0] hOne = pHdisplayWidth'(1);
    localparam logic [pVdisplayWidth-1:0] vOne = pVdisplayWidth'(1);

    // Read issued last cycle; its data is on iLayerDd/iLayerVdd this cycle.
    logic                      rdPend;
    // Two-entry output buffer, entry 0 is the head.
    logic [pColorDepth-1:0]    bufData [2];
    logic [1:0]                bufCnt;
    logic [1:0]                bufCntNext;
    logic [1:0]                cOcc;
    logic [1:0]                wrIdx;

    logic [pHdisplayWidth-1:0] hCnt;
    logic [pVdisplayWidth-1:0] vCnt;
    logic [pHdisplayWidth-1:0] hLast;
    logic [pVdisplayWidth-1:0] vLast;
    logic                      hAtLast;
    logic                      vAtLast;

    logic                      accept;
    logic                      skewErr;
    logic [pColorDepth-1:0]    mergedPix;
    logic                      found;

    assign hLast   = iHdisplay - hOne;
    assign vLast   = iVdisplay - vOne;
    assign hAtLast = (hCnt == hLast);
    assign vAtLast = (vCnt == vLast);

    assign oVd      = (bufCnt != 2'd0);
    assign accept   = oVd & iRdy;
    assign oPixel   = bufData[0];
    assign oHpos    = hCnt;
    assign oVpos    = vCnt;
    assign oFe      = accept & hAtLast & vAtLast;
    assign oSkewErr = skewErr;

    // Occupancy covers the read in flight as well as buffered pixels, so the
    // buffer can never overflow even when iRdy drops with a read outstanding.
    assign cOcc = {1'b0, rdPend} + bufCnt;

    always_comb begin
        oLayerEdd = 1'b0;
        if (!iRst && (iLayerEmp == '0)) begin
            oLayerEdd = (cOcc < 2'd2) | ((cOcc == 2'd2) & accept);
        end
    end

    // Priority composite: first opaque layer from index 0 upward wins. A layer
    // whose valid did not arrive is treated as transparent.
    always_comb begin
        mergedPix = iBgColor;
        found     = 1'b0;
        for (int unsigned k = 0; k < pLayerNum; k++) begin
            if (!found && iLayerVdd[k] &&
                (iLayerDd[k*pColorDepth +: pColorDepth] != pTransColor)) begin
                mergedPix = iLayerDd[k*pColorDepth +: pColorDepth];
                found     = 1'b1;
            end
        end
    end

    // The returning pixel lands behind whatever remains after this cycle's
    // dequeue, which is why the write slot accounts for accept.
    always_comb begin
        wrIdx      = bufCnt - {1'b0, accept};
        bufCntNext = bufCnt + {1'b0, rdPend} - {1'b0, accept};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rdPend     <= 1'b0;
            bufCnt     <= 2'd0;
            bufData[0] <= '0;
            bufData[1] <= '0;
            skewErr    <= 1'b0;
        end else begin
            rdPend <= oLayerEdd;
            bufCnt <= bufCntNext;
            if (accept) begin
                bufData[0] <= bufData[1];
            end
            // Placed after the shift so a write into slot 0 takes precedence.
            if (rdPend) begin
                if (wrIdx == 2'd0) begin
                    bufData[0] <= mergedPix;
                end else begin
                    bufData[1] <= mergedPix;
                end
                if (iLayerVdd != '1) begin
                    skewErr <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (accept) begin
            if (hAtLast) begin
                hCnt <= '0;
                vCnt <= vAtLast ? '0 : vCnt + vOne;
            end else begin
                hCnt <= hCnt + hOne;
            end
        end
    end

endmodule
